// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter chain: sample width, FIFO depth and
// the signed sample type used by both the FIR stage and the decimating FIFO.
package fir_pkg;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int LEVEL_W = 4;
    localparam int DCNT_W  = 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [LEVEL_W-1:0]       level_t;
    typedef logic [DCNT_W-1:0]        dcnt_t;

    // A sample is kept once enough samples have been skipped since the last
    // keep; comparing with >= lets a lowered factor take effect immediately.
    function automatic logic keep_sample(input dcnt_t dcnt, input dcnt_t factor);
        return (dcnt >= factor);
    endfunction

endpackage

// File: rtl/fir_decim_fifo_if.sv
// Output stream of the decimating FIFO: head sample, not-empty flag and the
// consumer's accept strobe.
interface fir_decim_fifo_if #(
    parameter int DATA_W = fir_pkg::DATA_W
);

    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count. A push into
// a full FIFO is accepted only when a pop frees the head slot on the same edge.
module fir_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     pop_req,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    output logic [3:0]               level,
    output logic                     drop
);
    import fir_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    level_t                   level_q, level_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];

    logic full;
    logic pop;
    logic wr_en;

    always_comb begin
        full     = (level_q == level_t'(DEPTH));
        rd_valid = (level_q != '0);
        pop      = rd_valid && pop_req;
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Power-of-two depth: natural pointer wrap gives modulo-DEPTH.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   level_d = level_q + level_t'(1);
            2'b01:   level_d = level_q - level_t'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the empty-gate on rd_data hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign level   = level_q;

endmodule

// File: rtl/fir_decim_fifo.sv
// Keeps one of every (decim+1) valid FIR samples and queues the kept samples
// in a FWFT FIFO; a sticky flag records any kept sample lost to a full FIFO.
module fir_decim_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] fir_result,
    input  logic                     in_en,
    input  logic [2:0]               decim,
    input  logic                     clear_ovf,
    output logic [3:0]               level,
    output logic                     overflow,
    fir_decim_fifo_if.master         out_if
);
    import fir_pkg::*;

    dcnt_t dcnt_q, dcnt_d;
    logic  overflow_q, overflow_d;
    logic  keep;
    logic  drop;

    always_comb begin
        keep   = in_en && keep_sample(dcnt_q, decim);
        dcnt_d = dcnt_q;
        if (in_en) begin
            dcnt_d = keep ? dcnt_t'(0) : dcnt_t'(dcnt_q + dcnt_t'(1));
        end

        // A drop on the same edge as a clear must still leave the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            dcnt_q     <= dcnt_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (keep),
        .wr_data  (fir_result),
        .pop_req  (out_if.out_ready),
        .rd_data  (out_if.out_data),
        .rd_valid (out_if.out_valid),
        .level    (level),
        .drop     (drop)
    );

    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench for fir_decim_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fir_decim_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] fir_result;
    logic                 in_en;
    logic [2:0]           decim;
    logic                 clear_ovf;
    logic [3:0]           level;
    logic                 overflow;

    fir_decim_fifo_if #(.DATA_W(DW)) dut_if();

    fir_decim_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .fir_result (fir_result),
        .in_en      (in_en),
        .decim      (decim),
        .clear_ovf  (clear_ovf),
        .level      (level),
        .overflow   (overflow),
        .out_if     (dut_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of kept samples, samples skipped since last keep.
    logic signed [DW-1:0] mq[$];
    int                   m_skipped;
    bit                   m_ovf;

    function automatic logic signed [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_skipped = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge(input logic signed [DW-1:0] s, input bit en,
                              input bit rdy, input bit clr);
        bit keep;
        bit dropped;
        keep    = 1'b0;
        dropped = 1'b0;
        if (en) begin
            if (m_skipped >= int'(decim)) begin
                keep      = 1'b1;
                m_skipped = 0;
            end else begin
                m_skipped++;
            end
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (keep) begin
            if (mq.size() < DP) mq.push_back(s);
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic signed [DW-1:0] s, input bit en,
                         input bit rdy, input bit clr);
        fir_result       = s;
        in_en            = en;
        dut_if.out_ready = rdy;
        clear_ovf        = clr;
        @(posedge clk);
        model_edge(s, en, rdy, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        fir_result       = '0;
        in_en            = 1'b0;
        dut_if.out_ready = 1'b0;
        clear_ovf        = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        fir_result       = '0;
        in_en            = 1'b0;
        decim            = '0;
        dut_if.out_ready = 1'b0;
        clear_ovf        = 1'b0;
        #1;
        checks++; if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", dut_if.out_valid); end
        checks++; if (dut_if.out_data !== '0) begin errors++; $display("FAIL reset out_data: got %0d want 0", dut_if.out_data); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset level: got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_passthrough();
        logic signed [DW-1:0] vin [4];
        logic signed [DW-1:0] vout [4];
        bit                   ven [4];
        vin  = '{8'sd5, -8'sd3, 8'sd7, 8'sd0};
        vout = '{8'sd5, -8'sd3, 8'sd7, 8'sd0};
        ven  = '{1'b1, 1'b1, 1'b1, 1'b0};
        decim = 3'd0;
        for (int i = 0; i < 4; i++) begin
            drive(vin[i], ven[i], 1'b1, 1'b0);
            checks++; if (dut_if.out_data !== vout[i]) begin errors++; $display("FAIL passthrough data[%0d]: got %0d want %0d", i, dut_if.out_data, vout[i]); end
            checks++; if (dut_if.out_valid !== ven[i]) begin errors++; $display("FAIL passthrough valid[%0d]: got %b want %b", i, dut_if.out_valid, ven[i]); end
            checks++; if (level > 4'd1) begin errors++; $display("FAIL passthrough level[%0d]: got %0d want <=1", i, level); end
        end
    endtask

    task automatic test_decim();
        do_reset();
        decim = 3'd2;
        for (int k = 1; k <= 9; k++) begin
            drive(DW'(k), 1'b1, 1'b0, 1'b0);
            checks++; if (level !== 4'(k / 3)) begin errors++; $display("FAIL decim level after %0d: got %0d want %0d", k, level, k / 3); end
        end
        for (int k = 1; k <= 3; k++) begin
            checks++; if (dut_if.out_data !== DW'(3 * k)) begin errors++; $display("FAIL decim head %0d: got %0d want %0d", k, dut_if.out_data, 3 * k); end
            drive('0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (dut_if.out_valid !== 1'b0) begin errors++; $display("FAIL decim drained valid: got %b want 0", dut_if.out_valid); end
        // Lowering the factor below the running count keeps the next sample.
        decim = 3'd7;
        for (int k = 0; k < 3; k++) drive(DW'(40 + k), 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL decim7 level: got %0d want 0", level); end
        decim = 3'd1;
        drive(8'sd50, 1'b1, 1'b0, 1'b0);
        checks++; if (dut_if.out_data !== 8'sd50 || level !== 4'd1) begin errors++; $display("FAIL decim lowered: got data %0d level %0d want 50 level 1", dut_if.out_data, level); end
    endtask

    task automatic test_overflow();
        do_reset();
        decim = 3'd0;
        for (int k = 10; k <= 19; k++) begin
            drive(DW'(k), 1'b1, 1'b0, 1'b0);
            if (k == 17) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf early: got %b want 0", overflow); end
            end
        end
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf level: got %0d want 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf flag: got %b want 1", overflow); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (dut_if.out_data !== DW'(10 + k)) begin errors++; $display("FAIL ovf pop %0d: got %0d want %0d", k, dut_if.out_data, 10 + k); end
            drive('0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (level !== 4'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf drained: got level %0d ovf %b want 0 1", level, overflow); end
        drive('0, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        decim = 3'd0;
        for (int k = 0; k < 8; k++) drive(DW'(30 + k), 1'b1, 1'b0, 1'b0);
        drive(8'sd20, 1'b1, 1'b1, 1'b0);
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL fullpp level: got %0d want 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp overflow: got %b want 0", overflow); end
        for (int k = 0; k < 8; k++) begin
            logic signed [DW-1:0] want;
            want = (k < 7) ? DW'(31 + k) : 8'sd20;
            checks++; if (dut_if.out_data !== want) begin errors++; $display("FAIL fullpp order %0d: got %0d want %0d", k, dut_if.out_data, want); end
            drive('0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_set_wins();
        decim = 3'd0;
        for (int k = 0; k < 8; k++) drive(DW'(40 + k), 1'b1, 1'b0, 1'b0);
        drive(8'sd48, 1'b1, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL setwins overflow: got %b want 1", overflow); end
        checks++; if (dut_if.out_data !== 8'sd40 || level !== 4'd8) begin errors++; $display("FAIL setwins contents: got head %0d level %0d want 40 8", dut_if.out_data, level); end
        drive('0, 1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL setwins clear: got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        decim = 3'd0;
        for (int k = 0; k < 3; k++) drive(DW'(60 + k), 1'b1, 1'b0, 1'b0);
        decim = 3'd3;
        drive(8'sd63, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL midrst pre level: got %0d want 3", level); end
        #2 reset = 1'b0;
        #1;
        checks++; if (dut_if.out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL midrst async: got valid %b level %0d want 0 0", dut_if.out_valid, level); end
        checks++; if (dut_if.out_data !== '0) begin errors++; $display("FAIL midrst data: got %0d want 0", dut_if.out_data); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        decim = 3'd1;
        for (int k = 0; k < 4; k++) begin
            drive(DW'(100 + k), 1'b1, 1'b0, 1'b0);
            checks++; if (level !== 4'((k + 1) / 2)) begin errors++; $display("FAIL midrst level %0d: got %0d want %0d", k, level, (k + 1) / 2); end
        end
        checks++; if (dut_if.out_data !== 8'sd101) begin errors++; $display("FAIL midrst head: got %0d want 101", dut_if.out_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic signed [DW-1:0] s;
            bit en, rdy, clr;
            if (i % 13 == 0 || $urandom_range(0, 9) == 0) decim = 3'($urandom_range(0, 7));
            s   = DW'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            drive(s, en, rdy, clr);
            checks++; if (dut_if.out_data !== exp_data()) begin errors++; $display("FAIL random data @%0d: got %0d want %0d", i, dut_if.out_data, exp_data()); end
            checks++; if (dut_if.out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL random valid @%0d: got %b want %b", i, dut_if.out_valid, mq.size() > 0); end
            checks++; if (level !== 4'(mq.size())) begin errors++; $display("FAIL random level @%0d: got %0d want %0d", i, level, mq.size()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL random overflow @%0d: got %b want %b", i, overflow, m_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_decim();
        test_overflow();
        test_full_push_pop();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
